// File: rtl/tmds_pkg.sv
// tmds_pkg
//   Definitions shared by the TMDS encoder and decoder of one channel:
//   the four 10-bit control tokens, the word-alignment FSM state encoding
//   and the token -> {C1,C0} lookup.
package tmds_pkg;

    // Control tokens as they appear on i_din[9:0] (bit 0 = first serial bit)
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'b00,
        ST_SETTLE = 2'b01,
        ST_LOCKED = 2'b10
    } tmds_state_e;

    // Returns {is_token, C1, C0}; C bits are 00 for non-token words.
    function automatic logic [2:0] tmds_token_lookup(input logic [9:0] word);
        logic [2:0] res;
        res = 3'b000;
        case (word)
            TMDS_CTRL_00: res = 3'b100;
            TMDS_CTRL_01: res = 3'b101;
            TMDS_CTRL_10: res = 3'b110;
            TMDS_CTRL_11: res = 3'b111;
            default:      res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tmds_word_dec.sv
// tmds_word_dec
//   Purely combinational decode of one 10-bit TMDS word.
//   Ports:
//     word     in   10  raw TMDS word, bit 0 = first serial bit
//     is_token out   1  word is one of the four control tokens
//     c        out   2  {C1,C0} of the token (00 when not a token)
//     data     out   8  decoded pixel byte (meaningful when not a token)
module tmds_word_dec (
    input  logic [9:0] word,
    output logic       is_token,
    output logic [1:0] c,
    output logic [7:0] data
);
    import tmds_pkg::*;

    logic [2:0] tok;
    logic [7:0] d;
    logic [6:0] diff;

    assign tok      = tmds_token_lookup(word);
    assign is_token = tok[2];
    assign c        = tok[1:0];

    // bit 9 flags DC-balance inversion, bit 8 selects XOR (1) or XNOR (0) chaining
    assign d    = word[9] ? ~word[7:0] : word[7:0];
    assign diff = d[7:1] ^ d[6:0];
    assign data = {(word[8] ? diff : ~diff), d[0]};

endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder
//   Receive side of one TMDS channel: aligns the deserializer word boundary
//   with bitslip pulses until a run of control tokens is seen, then decodes
//   each word into DE, {C1,C0} and the pixel byte with one cycle of latency.
//   Ports:
//     i_clk      in   1  pixel clock
//     i_rst_n    in   1  asynchronous active-low reset
//     i_din      in  10  raw TMDS word, bit 0 = first serial bit
//     o_bitslip  out  1  one-cycle pulse: shift the word boundary by one bit
//     o_slip_cnt out  4  bitslips applied, 0..9, wraps 9 -> 0
//     o_locked   out  1  word alignment achieved
//     o_de       out  1  1 = video data word
//     o_c        out  2  {C1,C0}, valid when o_de = 0
//     o_data     out  8  decoded pixel byte, valid when o_de = 1
module tmds_decoder #(
    parameter int P_TOKEN_RUN      = 8,
    parameter int P_SEARCH_TIMEOUT = 4096,
    parameter int P_SETTLE         = 16,
    parameter int P_LOSS_TIMEOUT   = 65536
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_din,
    output logic       o_bitslip,
    output logic [3:0] o_slip_cnt,
    output logic       o_locked,
    output logic       o_de,
    output logic [1:0] o_c,
    output logic [7:0] o_data
);
    import tmds_pkg::*;

    localparam int RUN_W  = $clog2(P_TOKEN_RUN) + 1;
    localparam int WORD_W = $clog2(P_SEARCH_TIMEOUT) + 1;
    localparam int SET_W  = $clog2(P_SETTLE) + 1;
    localparam int LOSS_W = $clog2(P_LOSS_TIMEOUT) + 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(P_TOKEN_RUN - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(P_SEARCH_TIMEOUT - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(P_SETTLE - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(P_LOSS_TIMEOUT - 1);

    // Increment that sticks at the all-ones value of a w-bit counter
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] top;
        top = (32'd1 << w) - 32'd1;
        return (v >= top) ? v : v + 32'd1;
    endfunction

    logic              tok;
    logic [1:0]        tok_c;
    logic [7:0]        dec_data;

    tmds_state_e       state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic [3:0]        slip_q, slip_d;
    logic              bitslip_q, bitslip_d;

    logic              vld_p1, vld_d;
    logic              de_p1, de_d;
    logic [1:0]        c_p1, c_d;
    logic [7:0]        data_p1, data_d;

    tmds_word_dec u_word_dec (
        .word     (i_din),
        .is_token (tok),
        .c        (tok_c),
        .data     (dec_data)
    );

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        word_d    = word_q;
        settle_d  = settle_q;
        loss_d    = loss_q;
        slip_d    = slip_q;
        bitslip_d = 1'b0;
        vld_d     = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                word_d = WORD_W'(sat_inc(32'(word_q), WORD_W));
                run_d  = tok ? RUN_W'(sat_inc(32'(run_q), RUN_W)) : '0;
                // Lock is tested first so it wins over a simultaneous timeout
                if (tok && (run_q == RUN_LAST)) begin
                    state_d = ST_LOCKED;
                    vld_d   = 1'b1;
                    loss_d  = '0;
                    word_d  = '0;
                    run_d   = '0;
                end else if (word_q == WORD_LAST) begin
                    // The pulse is registered, so it appears in the cycle
                    // after the timeout word and is never repeated.
                    state_d   = ST_SETTLE;
                    bitslip_d = 1'b1;
                    slip_d    = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
                    settle_d  = '0;
                end
            end
            ST_SETTLE: begin
                settle_d = SET_W'(sat_inc(32'(settle_q), SET_W));
                if (settle_q == SET_LAST) begin
                    state_d = ST_SEARCH;
                    word_d  = '0;
                    run_d   = '0;
                end
            end
            ST_LOCKED: begin
                vld_d  = 1'b1;
                loss_d = tok ? '0 : LOSS_W'(sat_inc(32'(loss_q), LOSS_W));
                if (!tok && (loss_q == LOSS_LAST)) begin
                    state_d = ST_SEARCH;
                    vld_d   = 1'b0;
                    loss_d  = '0;
                    word_d  = '0;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                word_d  = '0;
                run_d   = '0;
            end
        endcase

        // Decoded fields are gated by the lock state they are presented with
        de_d   = 1'b0;
        c_d    = 2'b00;
        data_d = 8'h00;
        if (vld_d) begin
            if (tok) begin
                c_d    = tok_c;
                data_d = data_p1;
            end else begin
                de_d   = 1'b1;
                c_d    = c_p1;
                data_d = dec_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_SEARCH;
            run_q     <= '0;
            word_q    <= '0;
            settle_q  <= '0;
            loss_q    <= '0;
            slip_q    <= 4'd0;
            bitslip_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            word_q    <= word_d;
            settle_q  <= settle_d;
            loss_q    <= loss_d;
            slip_q    <= slip_d;
            bitslip_q <= bitslip_d;
        end
    end

    // Stage p1: registered decode outputs, one cycle behind i_din
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1  <= 1'b0;
            de_p1   <= 1'b0;
            c_p1    <= 2'b00;
            data_p1 <= 8'h00;
        end else begin
            vld_p1  <= vld_d;
            de_p1   <= de_d;
            c_p1    <= c_d;
            data_p1 <= data_d;
        end
    end

    assign o_bitslip  = bitslip_q;
    assign o_slip_cnt = slip_q;
    assign o_locked   = vld_p1;
    assign o_de       = de_p1;
    assign o_c        = c_p1;
    assign o_data     = data_p1;

endmodule
